bf16_mul_arbiter: RTL and testbench



---
 rtl/bf16_pkg.sv | 13 +
 rtl/iv_fp_mul.sv | 82 ++++++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/bf16_mul_arbiter.sv | 135 +++++++++++++
 tb/tb_bf16_mul_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions: error codes, field width and the canonical NaN.
package bf16_pkg;

    localparam int BF16_WIDTH = 16;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_NAN  = 2'b11;

    localparam logic [BF16_WIDTH-1:0] BF16_QNAN = 16'h7FC0;

endpackage

// File: rtl/iv_fp_mul.sv
// Combinational bfloat16 multiplier. Subnormal inputs are treated as zero,
// rounding is round-to-nearest-even, overflow gives signed infinity and
// underflow gives signed zero. A NaN operand gives the canonical NaN; the
// invalid product inf x 0 gives the canonical NaN with its sign bit set.
module iv_fp_mul
    import bf16_pkg::*;
(
    input  logic [BF16_WIDTH-1:0] a,
    input  logic [BF16_WIDTH-1:0] b,
    output logic [BF16_WIDTH-1:0] out,
    output logic [1:0]            error
);

    logic               sign;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]        prod;
    logic [6:0]         frac;
    logic               guard;
    logic               sticky;
    logic               rnd;
    logic [8:0]         sig_r;
    logic signed [10:0] exp_base;
    logic signed [10:0] exp_norm;
    logic signed [10:0] exp_fin;

    // Classify operands, multiply significands, normalise, round, then pick the result class.
    always_comb begin
        sign   = a[15] ^ b[15];
        ea     = a[14:7];
        eb     = b[14:7];
        a_nan  = (ea == 8'hFF) && (a[6:0] != 7'd0);
        b_nan  = (eb == 8'hFF) && (b[6:0] != 7'd0);
        a_inf  = (ea == 8'hFF) && (a[6:0] == 7'd0);
        b_inf  = (eb == 8'hFF) && (b[6:0] == 7'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);

        prod     = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        exp_base = 11'(ea) + 11'(eb) - 11'sd127;

        // Significand product lies in [1,4); a set top bit means it is already >= 2.
        if (prod[15]) begin
            frac     = prod[14:8];
            guard    = prod[7];
            sticky   = |prod[6:0];
            exp_norm = exp_base + 11'sd1;
        end else begin
            frac     = prod[13:7];
            guard    = prod[6];
            sticky   = |prod[5:0];
            exp_norm = exp_base;
        end

        rnd   = guard & (sticky | frac[0]);
        sig_r = {2'b01, frac} + {8'd0, rnd};
        // A rounding carry leaves the fraction at zero and bumps the exponent.
        exp_fin = sig_r[8] ? exp_norm + 11'sd1 : exp_norm;

        out   = {sign, exp_fin[7:0], sig_r[6:0]};
        error = ERR_NONE;
        if (a_nan || b_nan) begin
            out   = BF16_QNAN;
            error = ERR_NAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            out   = BF16_QNAN | 16'h8000;
            error = ERR_NAN;
        end else if (a_inf || b_inf) begin
            out = {sign, 8'hFF, 7'd0};
        end else if (a_zero || b_zero) begin
            out = {sign, 15'd0};
        end else if (exp_fin >= 11'sd255) begin
            out   = {sign, 8'hFF, 7'd0};
            error = ERR_OVF;
        end else if (exp_fin <= 11'sd0) begin
            out   = {sign, 15'd0};
            error = ERR_UNF;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: first requester after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_any
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest active requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = ID_WIDTH'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bf16_mul_arbiter.sv
// Shares one bfloat16 multiplier among NUM_REQ requesters through a
// round-robin grant and a two-stage pipeline (S1 operands, S2 result).
// Handshake: a transfer happens on an edge where valid and ready are both
// high; senders hold valid and payload until then, and rsp_* hold while
// rsp_valid is high and rsp_ready is low.
module bf16_mul_arbiter
    import bf16_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                    rsp_err,
    output logic [ID_WIDTH-1:0]           rsp_id,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          ovf_cnt,
    output logic [CNT_WIDTH-1:0]          unf_cnt,
    output logic [CNT_WIDTH-1:0]          nan_cnt
);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;
    logic [ID_WIDTH-1:0]   s1_id;
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;
    logic [1:0]            s2_err;
    logic [ID_WIDTH-1:0]   s2_id;
    logic [ID_WIDTH-1:0]   ptr;

    logic                  s1_adv;
    logic                  s2_adv;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  grant_any;
    logic                  take;
    logic                  count_en;
    logic [DATA_WIDTH-1:0] mul_out;
    logic [1:0]            mul_err;

    assign s2_adv = ~s2_valid | rsp_ready;
    assign s1_adv = ~s1_valid | s2_adv;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Grant only goes to an asserted valid, so a visible grant is a transfer.
    assign req_ready = grant & {NUM_REQ{s1_adv}};
    assign take      = grant_any & s1_adv;
    assign count_en  = s1_valid & s2_adv;

    iv_fp_mul u_mul (
        .a     (s1_a),
        .b     (s1_b),
        .out   (mul_out),
        .error (mul_err)
    );

    // S1: capture the granted operands; empties when it advances without a new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            ptr      <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            if (s1_adv) s1_valid <= take;
            if (take) begin
                s1_a  <= req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                s1_b  <= req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                s1_id <= grant_idx;
                ptr   <= grant_idx;
            end
        end
    end

    // S2: register the multiplier result; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= ERR_NONE;
            s2_id    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= mul_out;
                s2_err  <= mul_err;
                s2_id   <= s1_id;
            end
        end
    end

    // Saturating error counters; a clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
            nan_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
            nan_cnt <= '0;
        end else if (count_en) begin
            if (mul_err == ERR_OVF && ovf_cnt != {CNT_WIDTH{1'b1}}) ovf_cnt <= ovf_cnt + 1'b1;
            if (mul_err == ERR_UNF && unf_cnt != {CNT_WIDTH{1'b1}}) unf_cnt <= unf_cnt + 1'b1;
            if (mul_err == ERR_NAN && nan_cnt != {CNT_WIDTH{1'b1}}) nan_cnt <= nan_cnt + 1'b1;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_data;
    assign rsp_err   = s2_err;
    assign rsp_id    = s2_id;

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Bench for bf16_mul_arbiter: directed cases plus randomized traffic
// scored against a real-arithmetic multiplier model and a round-robin model.
module tb_bf16_mul_arbiter;
    import bf16_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;
    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 2;
    localparam int CNT_MAX    = 3;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b = '0;
    logic                          rsp_valid;
    logic                          rsp_ready = 1'b1;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [1:0]                    rsp_err;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic                          cnt_clr = 1'b0;
    logic [CNT_WIDTH-1:0]          ovf_cnt, unf_cnt, nan_cnt;

    int checks = 0;
    int errors = 0;

    logic [19:0]        exp_q[$];
    int                 grant_log[$];
    int                 last_grant = NUM_REQ - 1;
    int                 n_acc = 0;
    int                 mdl_ovf = 0, mdl_unf = 0, mdl_nan = 0;
    logic [NUM_REQ-1:0] xfer = '0;
    logic               hold_pending = 1'b0;
    logic [20:0]        held = '0;
    int                 exp_id, got_id, probe;
    logic               found;
    logic [19:0]        e_ent;

    bf16_mul_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_id    (rsp_id),
        .cnt_clr   (cnt_clr),
        .ovf_cnt   (ovf_cnt),
        .unf_cnt   (unf_cnt),
        .nan_cnt   (nan_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    // Reference multiply: exact real product, then round-to-nearest-even to bf16.
    function automatic logic [17:0] mul_model(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int   ea, eb, ip, e2, be;
        real  x, sc, fr;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        if ((ea == 255 && a[6:0] != 0) || (eb == 255 && b[6:0] != 0)) return {ERR_NAN, 16'h7FC0};
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return {ERR_NAN, 16'hFFC0};
        if (ea == 255 || eb == 255) return {ERR_NONE, s, 8'hFF, 7'd0};
        if (ea == 0 || eb == 0) return {ERR_NONE, s, 15'd0};
        x  = (1.0 + real'(int'(a[6:0])) / 128.0) * (1.0 + real'(int'(b[6:0])) / 128.0)
             * pow2(ea + eb - 254);
        e2 = 0;
        while (x >= 2.0) begin x = x / 2.0; e2++; end
        while (x < 1.0) begin x = x * 2.0; e2--; end
        sc = x * 128.0;
        ip = $rtoi(sc);
        fr = sc - real'(ip);
        if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
        if (ip == 256) begin ip = 128; e2++; end
        be = e2 + 127;
        if (be >= 255) return {ERR_OVF, s, 8'hFF, 7'd0};
        if (be <= 0) return {ERR_UNF, s, 15'd0};
        return {ERR_NONE, s, 8'(be), 7'(ip)};
    endfunction

    function automatic logic [15:0] gen_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0:       v[14:7] = 8'hFF;
            1:       v[14:7] = 8'h00;
            2:       v[14:7] = 8'($urandom_range(190, 254));
            3:       v[14:7] = 8'($urandom_range(1, 64));
            default: v[14:7] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // Scoreboard: observe transfers and responses midway between active edges.
    always @(negedge clk) begin
        if (rst_n) begin
            xfer = req_valid & req_ready;
            check("ready_legal", 32'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == 0)), 1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", 1, 0);
                end else begin
                    e_ent = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e_ent[19:18]));
                    check("rsp_err", 32'(rsp_err), 32'(e_ent[17:16]));
                    check("rsp_data", 32'(rsp_data), 32'(e_ent[15:0]));
                    if (e_ent[17:16] == ERR_OVF) mdl_ovf++;
                    if (e_ent[17:16] == ERR_UNF) mdl_unf++;
                    if (e_ent[17:16] == ERR_NAN) mdl_nan++;
                end
            end
            if (xfer != 0) begin
                exp_id = last_grant;
                found  = 1'b0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    probe = (last_grant + k) % NUM_REQ;
                    if (!found && req_valid[probe]) begin
                        exp_id = probe;
                        found  = 1'b1;
                    end
                end
                got_id = 0;
                for (int i = 0; i < NUM_REQ; i++) if (xfer[i]) got_id = i;
                check("grant_id", 32'(got_id), 32'(exp_id));
                last_grant = got_id;
                grant_log.push_back(got_id);
                n_acc++;
                exp_q.push_back({2'(got_id), mul_model(req_a[got_id*16 +: 16], req_b[got_id*16 +: 16])});
            end
            if (hold_pending) check("rsp_hold", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'(held));
            hold_pending = rsp_valid && !rsp_ready;
            held         = {rsp_valid, rsp_id, rsp_err, rsp_data};
        end
    end

    task automatic bench_reset_state();
        exp_q.delete();
        grant_log.delete();
        last_grant   = NUM_REQ - 1;
        mdl_ovf      = 0;
        mdl_unf      = 0;
        mdl_nan      = 0;
        hold_pending = 1'b0;
        xfer         = '0;
        req_valid    = '0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_ovf"}, 32'(ovf_cnt), 32'(sat(mdl_ovf)));
        check({tag, "_unf"}, 32'(unf_cnt), 32'(sat(mdl_unf)));
        check({tag, "_nan"}, 32'(nan_cnt), 32'(sat(mdl_nan)));
    endtask

    task automatic clear_counters();
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        mdl_ovf = 0;
        mdl_unf = 0;
        mdl_nan = 0;
    endtask

    // Randomized requesters that hold payload until accepted.
    task automatic drive_random(input int cycles, input int valid_pct, input int busy_pct);
        repeat (cycles) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || xfer[i]) begin
                    if ($urandom_range(0, 99) < valid_pct) begin
                        req_valid[i]       = 1'b1;
                        req_a[i*16 +: 16] = gen_op();
                        req_b[i*16 +: 16] = gen_op();
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 99) < busy_pct) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_valid != 0 || exp_q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~xfer;
            rsp_ready = 1'b1;
            n++;
        end
        check("drain_done", 32'({req_valid != 0, exp_q.size() != 0}), 0);
    endtask

    // One request on an idle pipeline with its latency and result checked directly.
    task automatic send_check(input int lane, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] exp_data, input logic [1:0] exp_err);
        int n;
        @(posedge clk); #1;
        rsp_ready             = 1'b1;
        req_a[lane*16 +: 16] = a;
        req_b[lane*16 +: 16] = b;
        req_valid[lane]       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[lane] && n < 20);
        check("send_ready", 32'(req_ready[lane]), 1);
        @(posedge clk); #1;
        req_valid[lane] = 1'b0;
        @(negedge clk);
        check("lat_early", 32'(rsp_valid), 0);
        @(negedge clk);
        check("lat_valid", 32'(rsp_valid), 1);
        check("dir_data", 32'(rsp_data), 32'(exp_data));
        check("dir_err", 32'(rsp_err), 32'(exp_err));
        check("dir_id", 32'(rsp_id), 32'(lane));
    endtask

    int acc0;

    initial begin
        // Power-on reset values
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_data", 32'(rsp_data), 0);
        check("rst_err", 32'(rsp_err), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_cnt", 32'({ovf_cnt, unf_cnt, nan_cnt}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single NaN request on lane 2
        send_check(2, 16'h7FC0, 16'h3F80, 16'h7FC0, ERR_NAN);
        check("single_nan_cnt", 32'(nan_cnt), 1);

        // Error routing
        send_check(0, 16'h7F80, 16'h0000, 16'hFFC0, ERR_NAN);
        send_check(1, 16'h7F00, 16'h7F00, 16'h7F80, ERR_OVF);
        send_check(3, 16'h0180, 16'h0180, 16'h0000, ERR_UNF);
        send_check(1, 16'h3FC0, 16'h4040, 16'h4090, ERR_NONE);
        drain();
        check_counters("route_cnt");

        // Saturation at all-ones
        clear_counters();
        check_counters("clr_cnt");
        for (int i = 0; i < 4; i++) send_check(i, 16'h7FC0, 16'h3F80, 16'h7FC0, ERR_NAN);
        drain();
        check("sat_nan", 32'(nan_cnt), CNT_MAX);

        // Clear in the same cycle as a NaN increment
        @(posedge clk); #1;
        req_a[15:0] = 16'h7FC1;
        req_b[15:0] = 16'h3F80;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("clr_race_ready", 32'(req_ready[0]), 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        cnt_clr      = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_race_nan", 32'(nan_cnt), 0);
        @(posedge clk); #1;
        mdl_ovf = 0;
        mdl_unf = 0;
        mdl_nan = 0;
        drain();
        check_counters("clr_race_cnt");

        // Fairness from reset
        rst_n = 1'b0;
        bench_reset_state();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_random(10, 100, 0);
        drain();
        check("fair_len", 32'(grant_log.size() >= 8), 1);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) check("fair_seq", 32'(grant_log[k]), 32'(k % NUM_REQ));

        // Backpressure: five stalled cycles admit exactly two requests
        acc0 = n_acc;
        drive_random(5, 100, 100);
        check("bp_accepted", 32'(n_acc - acc0), 2);
        drive_random(4, 100, 0);
        drain();

        // Random traffic
        drive_random(400, 60, 30);
        drain();
        check_counters("rand_cnt");

        // Reset with both stages full
        drive_random(3, 100, 100);
        rst_n = 1'b0;
        bench_reset_state();
        #1;
        check("midrst_valid", 32'(rsp_valid), 0);
        check("midrst_data", 32'(rsp_data), 0);
        check("midrst_cnt", 32'({ovf_cnt, unf_cnt, nan_cnt}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_random(6, 100, 0);
        drain();
        check("midrst_first", 32'((grant_log.size() > 0) ? grant_log[0] : -1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
